// File: rtl/display_scan_controller_if.sv
// Bundles the game-side controls and the pad-side drive of the multi-digit display.
// The scan controller is the slave: it consumes the digit data and drives the pads.
interface display_scan_controller_if;
  logic        en;
  logic [15:0] digit_val;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [1:0]  active_digit;
  logic        frame_start;

  modport slave (
    input  en, digit_val, blank_mask, brightness,
    output seg, dig_en, active_digit, frame_start
  );

  modport master (
    output en, digit_val, blank_mask, brightness,
    input  seg, dig_en, active_digit, frame_start
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scanner: per-slot blanking, 16-level PWM, per-digit mask.
// All outputs registered; a slot's inputs are latched on the edge that starts it.
module sevenseg_driver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = '0;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end
endmodule

module display_scan_controller #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  display_scan_controller_if.slave    bus
);
  localparam int KW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] K_BLANK = KW'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]    d_q, d_d;
  logic [3:0]    nib_q, nib_d;
  logic          mask_q, mask_d;
  logic [3:0]    bri_q, bri_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    den_q, den_d;
  logic [1:0]    act_q, act_d;
  logic          fs_q, fs_d;

  logic          latch;
  logic [3:0]    pwm_p;
  logic [6:0]    seg_dec;

  sevenseg_driver u_dec (
    .nibble (nib_q),
    .seg    (seg_dec)
  );

  // Outputs are computed for the slot position being entered, so they line up with k_d/d_d.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    nib_d   = nib_q;
    mask_d  = mask_q;
    bri_d   = bri_q;
    act_d   = act_q;
    seg_d   = '0;
    den_d   = '0;
    fs_d    = 1'b0;
    latch   = 1'b0;
    pwm_p   = '0;

    if (!bus.en) begin
      state_d = IDLE;
      k_d     = '0;
      d_d     = '0;
      act_d   = '0;
    end else begin
      if (state_q == IDLE) begin
        state_d = BLANK;
        k_d     = '0;
        d_d     = '0;
        latch   = 1'b1;
      end else if (k_q == K_LAST) begin
        state_d = BLANK;
        k_d     = '0;
        d_d     = d_q + 2'd1;
        latch   = 1'b1;
      end else begin
        k_d     = k_q + 1'b1;
        state_d = (k_d >= K_BLANK) ? DRIVE : BLANK;
      end

      if (latch) begin
        nib_d  = bus.digit_val[{d_d, 2'b00} +: 4];
        mask_d = bus.blank_mask[d_d];
        bri_d  = bus.brightness;
        fs_d   = (d_d == 2'd0);
        act_d  = d_d;
      end

      // PWM phase wraps every 16 cycles from the first drive cycle of the slot.
      if (state_d == DRIVE) begin
        pwm_p = 4'(k_d - K_BLANK);
        if (!mask_q && (pwm_p <= bri_q)) begin
          den_d = 4'b0001 << d_q;
          seg_d = seg_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      d_q     <= '0;
      nib_q   <= '0;
      mask_q  <= 1'b0;
      bri_q   <= '0;
      seg_q   <= '0;
      den_q   <= '0;
      act_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
      nib_q   <= nib_d;
      mask_q  <= mask_d;
      bri_q   <= bri_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      act_q   <= act_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.dig_en       = den_q;
  assign bus.active_digit = act_q;
  assign bus.frame_start  = fs_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller at SCAN_DIV=40, BLANK_CYCLES=8: per-slot scoreboard
// fed from a vector table, plus hand sequences for tearing, enable drop and async reset.
module tb_display_scan_controller;
  localparam int SD = 40;
  localparam int BC = 8;

  logic clk;
  logic rst_n;

  display_scan_controller_if bus ();

  display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     dv;
    logic [3:0]      mask;
    logic [3:0]      bri;
    logic [3:0][6:0] segs;
  } vec_t;

  typedef struct {
    logic [SD-1:0] on_map;
    logic [SD-1:0] fs_map;
    logic [6:0]    seg;
    logic [3:0]    den;
    logic [1:0]    act;
    int            stray;
  } slot_t;

  vec_t  tbl [7];
  slot_t exp_q [$];
  int    vec_cnt = 0;
  int    err_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic slot_t make_exp(input int d, input logic m, input logic [3:0] bri,
                                     input logic [6:0] s);
    slot_t e;
    e.on_map = '0;
    for (int k = 0; k < SD; k++)
      if (!m && k >= BC && ((k - BC) % 16) <= int'(bri)) e.on_map[k] = 1'b1;
    e.fs_map = (d == 0) ? SD'(1) : '0;
    e.seg    = m ? 7'h00 : s;
    e.den    = m ? 4'h0 : (4'b0001 << d);
    e.act    = 2'(d);
    e.stray  = 0;
    return e;
  endfunction

  // Samples one whole slot on falling edges; optionally changes digit 0 after sample tear_k.
  task automatic observe(input int tear_k, output slot_t o);
    bit seen;
    seen     = 0;
    o.on_map = '0;
    o.fs_map = '0;
    o.seg    = '0;
    o.den    = '0;
    o.act    = '0;
    o.stray  = 0;
    for (int k = 0; k < SD; k++) begin
      @(negedge clk);
      if (bus.dig_en != 4'h0) begin
        o.on_map[k] = 1'b1;
        if (!seen) begin
          o.seg = bus.seg;
          o.den = bus.dig_en;
          seen  = 1;
        end else if (bus.seg != o.seg || bus.dig_en != o.den) begin
          o.stray++;
        end
      end else if (bus.seg != 7'h00) begin
        o.stray++;
      end
      if (bus.frame_start) o.fs_map[k] = 1'b1;
      if (k == 0) o.act = bus.active_digit;
      else if (bus.active_digit != o.act) o.stray++;
      if (k == tear_k) bus.digit_val[3:0] = 4'h1;
    end
  endtask

  task automatic run_slot(input int d, input logic m, input logic [3:0] bri,
                          input logic [6:0] s, input int tear_k, input string tag);
    slot_t o, e;
    exp_q.push_back(make_exp(d, m, bri, s));
    observe(tear_k, o);
    e = exp_q.pop_front();
    chk($sformatf("%s d%0d on_map", tag, d), 64'(o.on_map), 64'(e.on_map));
    chk($sformatf("%s d%0d frame_start", tag, d), 64'(o.fs_map), 64'(e.fs_map));
    chk($sformatf("%s d%0d seg", tag, d), 64'(o.seg), 64'(e.seg));
    chk($sformatf("%s d%0d dig_en", tag, d), 64'(o.den), 64'(e.den));
    chk($sformatf("%s d%0d active_digit", tag, d), 64'(o.act), 64'(e.act));
    chk($sformatf("%s d%0d stray", tag, d), 64'(o.stray), 64'(e.stray));
  endtask

  function automatic logic [13:0] outs();
    return {bus.seg, bus.dig_en, bus.active_digit, bus.frame_start};
  endfunction

  initial begin
    tbl[0] = '{16'h3210, 4'b0000, 4'd15, {7'h4F, 7'h5B, 7'h06, 7'h3F}};
    tbl[1] = '{16'h3210, 4'b0000, 4'd3,  {7'h4F, 7'h5B, 7'h06, 7'h3F}};
    tbl[2] = '{16'h3210, 4'b0000, 4'd0,  {7'h4F, 7'h5B, 7'h06, 7'h3F}};
    tbl[3] = '{16'h3210, 4'b0100, 4'd15, {7'h4F, 7'h5B, 7'h06, 7'h3F}};
    tbl[4] = '{16'h957A, 4'b1001, 4'd7,  {7'h6F, 7'h6D, 7'h07, 7'h77}};
    tbl[5] = '{16'hEDCB, 4'b0000, 4'd9,  {7'h79, 7'h5E, 7'h39, 7'h7C}};
    tbl[6] = '{16'h864F, 4'b0010, 4'd14, {7'h7F, 7'h7D, 7'h66, 7'h71}};

    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.digit_val  = '0;
    bus.blank_mask = '0;
    bus.brightness = '0;
    #1;
    chk("reset outputs", 64'(outs()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle outputs en=0", 64'(outs()), 64'd0);

    // Back-to-back frames: new table row presented just before each digit-0 slot starts.
    bus.en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      bus.digit_val  = tbl[v].dv;
      bus.blank_mask = tbl[v].mask;
      bus.brightness = tbl[v].bri;
      for (int d = 0; d < 4; d++)
        run_slot(d, tbl[v].mask[d], tbl[v].bri, tbl[v].segs[d], -1, $sformatf("vec%0d", v));
    end

    // Digit 0 changes mid-slot: the old pattern holds until the next digit-0 slot.
    bus.digit_val  = 16'h3210;
    bus.blank_mask = 4'b0000;
    bus.brightness = 4'd15;
    run_slot(0, 1'b0, 4'd15, 7'h3F, 20, "tear");
    run_slot(1, 1'b0, 4'd15, 7'h06, -1, "tear");
    run_slot(2, 1'b0, 4'd15, 7'h5B, -1, "tear");
    run_slot(3, 1'b0, 4'd15, 7'h4F, -1, "tear");
    run_slot(0, 1'b0, 4'd15, 7'h06, -1, "tear next");
    run_slot(1, 1'b0, 4'd15, 7'h06, -1, "pre-drop");

    // Enable dropped at k=15 of the digit-2 slot.
    repeat (16) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en drop next cycle", 64'(outs()), 64'd0);
    repeat (4) @(negedge clk);
    chk("en low idle", 64'(outs()), 64'd0);
    bus.en = 1'b1;
    run_slot(0, 1'b0, 4'd15, 7'h06, -1, "reenable");

    // Asynchronous reset in the middle of the digit-1 drive phase.
    repeat (13) @(negedge clk);
    chk("drive before reset", 64'(bus.dig_en), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset clears", 64'(outs()), 64'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post reset idle", 64'(outs()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes four 4-bit digit values onto one shared seven-segment bus, with one active-high enable per digit.
- Scans digits 0,1,2,3 in order, then wraps.
- Inserts a blanking interval at the start of each digit slot to prevent ghosting.
- Applies 16-level PWM brightness and a per-digit blank mask.
- Sits between the game multiplexer and the pads, and replaces a direct sevenseg_driver connection when a multi-digit display is fitted.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot. Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off. Must be at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  scan enable
- digit_val  input  16  digit d value on bits [4d+3:4d]
- blank_mask  input  4  bit d = 1 forces digit d dark
- brightness  input  4  0 = 1/16 duty, 15 = full duty
- seg  output  7  segment drive, active-high; seg[0]=a … seg[6]=g
- dig_en  output  4  digit enable, one-hot or zero, active-high
- active_digit  output  2  index of the current slot
- frame_start  output  1  one-cycle pulse when the digit-0 slot begins

Behaviour:
- Interface:
  - One clock: clk.
  - Reset rst_n is asynchronous and active-low.
  - While rst_n is low: seg=0, dig_en=0, active_digit=0, frame_start=0, and all counters and latches are cleared.
- Registered outputs: all outputs are driven from flops; there is no combinational input-to-output path.
- State machine:
  - IDLE:
    - Entered from reset, or whenever en is sampled low.
    - All outputs 0; slot counter k=0; digit index=0.
    - Leaves when en is sampled high. The next cycle is k=0 of the digit-0 slot.
  - BLANK:
    - Slot cycles k = 0 … BLANK_CYCLES-1.
    - At k=0, latch digit_val[4d+3:4d], blank_mask[d] and brightness for the current digit d. Inputs are not re-sampled until the next slot, so there is no mid-slot tearing.
    - In the same cycle, frame_start=1 if d=0, and active_digit=d.
    - dig_en=0 and seg=0 for the whole phase.
  - DRIVE:
    - Slot cycles k = BLANK_CYCLES … SCAN_DIV-1.
    - PWM phase p = (k-BLANK_CYCLES) mod 16, a 4-bit wrap.
    - Digit is on when the latched mask bit is 0 and p ≤ latched brightness.
    - When on: dig_en = one-hot(d) and seg = sevenseg_driver pattern of the latched nibble.
    - When off: dig_en=0 and seg=0.
    - At k=SCAN_DIV-1: k becomes 0 and d becomes (d+1) mod 4, then return to BLANK.
- Segment encoding: reuse the sevenseg_driver instance. 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F.
- Slot counter width is ceil(log2(SCAN_DIV)). A full frame is 4·SCAN_DIV cycles.
- Slot timing never depends on blank_mask or brightness. A masked digit still consumes its full slot.
- en deasserted mid-slot:
  - All outputs 0 the next cycle; go to IDLE.
  - The scan restarts at digit 0, BLANK, on re-enable.
- rst_n asserted mid-DRIVE: outputs clear immediately, asynchronously. After release, remain in IDLE until en is sampled high.
- Input changes in the same cycle as slot rollover are captured by the new slot's latch.

Test Plan (SCAN_DIV=40, BLANK_CYCLES=8):
1. Reset: assert rst_n=0 mid-DRIVE → seg, dig_en, frame_start, active_digit = 0 with no clock edge needed; after release with en=0, outputs stay 0.
2. Scan order: digit_val=16'h3210, mask=0, brightness=15, raise en →
   - Digit-0 slot: 8 cycles dig_en=0, then 32 cycles dig_en=0001, seg=0x3F.
   - Next slots: 0010/0x06, 0100/0x5B, 1000/0x4F.
   - frame_start pulses every 160 cycles, aligned to active_digit=0.
3. PWM: brightness=3 → within each 32-cycle DRIVE, dig_en is high for p=0..3 of each 16-cycle window, i.e. 8 cycles on and 24 off. brightness=0 → 2 cycles on.
4. Mask: blank_mask=4'b0100 → digit-2 slot has dig_en=0 and seg=0 for all 40 cycles; the slots of digits 0, 1 and 3 are unchanged in timing.
5. Tear-free: change digit_val[3:0] from 0 to 1 at k=20 of the digit-0 slot → seg stays 0x3F to the end of that slot; 0x06 appears only in the next digit-0 slot.
6. Enable drop: deassert en at k=15 of the digit-2 slot → all outputs 0 next cycle; on re-enable, the first DRIVE cycle shows digit 0 after 8 blank cycles.
